demux_frame_ctrl: RTL and testbench
===================================

DEMUX_FRAME_CTRL -- requirements
Module: demux_frame_ctrl

Interface
REQ-001 The block SHALL have parameter PLEN, default 4, giving payload bits per frame; the legal range SHALL be 1..255.
REQ-002 clk  input  1  Single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous and active-low.
REQ-004 din  input  1  Serial data bit, qualified by din_valid.
REQ-005 din_valid  input  1  din/sof valid; a beat is accepted when din_valid and din_ready are both 1.
REQ-006 sof  input  1  Start-of-frame marker; on an accepted beat it marks din as the header bit (destination channel).
REQ-007 din_ready  output  1  Block can accept a beat this cycle.
REQ-008 i  output  1  Data bit to the downstream 1x2 demux.
REQ-009 s  output  1  Select to the downstream 1x2 demux: 0 = y[0], 1 = y[1].
REQ-010 y_valid  output  1  i is a valid payload bit this cycle.
REQ-011 frame_done  output  1  One-cycle pulse on the last payload bit of a completed frame.
REQ-012 err  output  1  Sticky protocol error flag.
REQ-013 err_clr  input  1  Synchronous clear of err.
REQ-014 cnt0, cnt1  output  8 each  Completed-frame counts for channel 0 and channel 1.

Function
REQ-015 The FSM SHALL have three states: IDLE, PAYLOAD and GAP.
REQ-016 din_ready SHALL be 1 in IDLE and PAYLOAD, and 0 in GAP; it SHALL be derived from the state register only.
REQ-017 In IDLE, an accepted beat with sof=1 SHALL load s<=din, clear the beat counter and move to PAYLOAD.
REQ-018 In IDLE, accepted beats with sof=0 SHALL be consumed and discarded, with no output change.
REQ-019 In PAYLOAD, each accepted beat with sof=0 SHALL register i<=din and y_valid<=1 and increment the beat counter.
REQ-020 Latency: a payload beat accepted at edge k SHALL appear on i/y_valid in the cycle after edge k, for exactly one cycle.
REQ-021 In any cycle with no accepted payload beat, y_valid SHALL be 0 and i SHALL be 0.
REQ-022 s SHALL hold its value between headers, including across frames and while idle.
REQ-023 When the PLEN-th payload beat is accepted, frame_done SHALL be 1 in the same cycle as that beat's y_valid.
REQ-024 At that same edge, cnt[s] SHALL increment and the FSM SHALL go to GAP.
REQ-025 GAP SHALL last exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-026 cnt0 and cnt1 SHALL wrap modulo 256 (255+1 -> 0) without affecting err.
REQ-027 An accepted beat with sof=1 in PAYLOAD SHALL abort the frame with these effects:
- err<=1;
- no y_valid and no frame_done for that beat;
- no counter increment;
- the beat is taken as a new header (s<=din, beat counter<=0), remaining in PAYLOAD.
REQ-028 If err_clr=1 and a new error occur in the same cycle, set SHALL win and err SHALL remain 1.
REQ-029 Beats presented during GAP SHALL NOT be accepted; the source holds them per the valid/ready rule.

Reset
REQ-030 While rst_n=0, the following SHALL be forced immediately, independent of clk:
- state=IDLE, beat counter=0;
- i=0, s=0, y_valid=0, frame_done=0, err=0, cnt0=cnt1=0.
REQ-031 din_ready SHALL be 1 during and after reset (IDLE).
REQ-032 Reset asserted mid-frame SHALL discard the partial frame: no frame_done and no counter change after release.

Verification
REQ-033 Reset: assert rst_n=0 mid-PAYLOAD, asynchronously to clk -> all outputs 0 at once; din_ready=1; cnt0=cnt1=0.
REQ-034 PLEN=4, contiguous beats sof/din=1/1, then payload 1,0,1,1 -> s=1; i=1,0,1,1 with y_valid high for 4 cycles; frame_done on the 4th; cnt1 0->1; din_ready=0 for 1 cycle, then 1.
REQ-035 Header 0, payload 0,1,1,0 with din_valid low between beats -> y_valid only in the cycles after accepted beats; i=0,1,1,0; cnt0=1; s stays 0 afterwards.
REQ-036 Header 1, two payload beats, then sof/din=1/0 -> err=1; cnt1 unchanged; s=0; the next 4 beats complete the frame with cnt0=1; err_clr then clears err to 0.
REQ-037 Three beats with sof=0 in IDLE -> y_valid stays 0; counters unchanged; the next sof beat is accepted as a header.
REQ-038 256 complete frames to channel 0 -> cnt0 goes 255 -> 0 on the 256th; cnt1=0; err=0.

Source files
------------

// File: rtl/demux_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// demux_frame_ctrl_if
// Bundles the serial frame input, the 1x2 demux drive signals and the status
// outputs of demux_frame_ctrl into one interface.
//   master : frame source / supervisor side (drives din, din_valid, sof, err_clr)
//   slave  : demux_frame_ctrl side (drives din_ready, i, s, y_valid,
//            frame_done, err, cnt0, cnt1)
// -----------------------------------------------------------------------------
interface demux_frame_ctrl_if;
   logic       din;
   logic       din_valid;
   logic       sof;
   logic       din_ready;
   logic       i;
   logic       s;
   logic       y_valid;
   logic       frame_done;
   logic       err;
   logic       err_clr;
   logic [7:0] cnt0;
   logic [7:0] cnt1;

   modport master (
      output din, din_valid, sof, err_clr,
      input  din_ready, i, s, y_valid, frame_done, err, cnt0, cnt1
   );

   modport slave (
      input  din, din_valid, sof, err_clr,
      output din_ready, i, s, y_valid, frame_done, err, cnt0, cnt1
   );
endinterface : demux_frame_ctrl_if

// File: rtl/demux_frame_ctrl.sv
// -----------------------------------------------------------------------------
// demux_frame_ctrl
// Receives serial frames (one header bit giving the destination channel,
// followed by PLEN payload bits) and drives a downstream 1x2 demux:
// s selects the channel, i/y_valid carry each payload bit one cycle after it
// is accepted. Counts completed frames per channel and flags aborted frames.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : demux_frame_ctrl_if.slave (din/din_valid/sof/err_clr in,
//           din_ready/i/s/y_valid/frame_done/err/cnt0/cnt1 out)
// Parameter:
//   PLEN  : payload bits per frame, 1..255
// -----------------------------------------------------------------------------
module demux_frame_ctrl #(
   parameter int PLEN = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   demux_frame_ctrl_if.slave   bus
);

   localparam logic [7:0] LAST_BEAT = 8'(PLEN - 1);

   typedef enum logic [1:0] {IDLE, PAYLOAD, GAP} state_t;

   state_t     state;
   state_t     state_nxt;
   logic       ready;
   logic       accept;
   logic       last_beat;
   logic       abort;
   logic [7:0] beat_cnt;
   logic       i_q;
   logic       s_q;
   logic       y_valid_q;
   logic       frame_done_q;
   logic       err_q;
   logic [7:0] cnt0_q;
   logic [7:0] cnt1_q;

   assign accept    = bus.din_valid & ready;
   assign last_beat = (beat_cnt == LAST_BEAT);
   // A header arriving mid-frame restarts the frame and is reported as an error.
   assign abort     = accept & bus.sof & (state == PAYLOAD);

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   // NOTE: the default assignment first keeps this purely combinational; a
   // path that left state_nxt unassigned would infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept && bus.sof) state_nxt = PAYLOAD;
         PAYLOAD: if (accept && !bus.sof && last_beat) state_nxt = GAP;
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: ready depends on the state register only, so it never
   // combinationally follows din_valid.
   always_comb begin
      ready = (state != GAP);
   end

   // Datapath: header capture, payload forwarding, frame counting, error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt     <= '0;
         i_q          <= 1'b0;
         s_q          <= 1'b0;
         y_valid_q    <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
      end else begin
         // Payload outputs are single-cycle strobes.
         i_q          <= 1'b0;
         y_valid_q    <= 1'b0;
         frame_done_q <= 1'b0;

         if (accept && bus.sof) begin
            s_q      <= bus.din;
            beat_cnt <= '0;
         end else if (accept && state == PAYLOAD) begin
            i_q       <= bus.din;
            y_valid_q <= 1'b1;
            beat_cnt  <= beat_cnt + 8'd1;
            if (last_beat) begin
               frame_done_q <= 1'b1;
               if (s_q) cnt1_q <= cnt1_q + 8'd1;
               else     cnt0_q <= cnt0_q + 8'd1;
            end
         end

         // Set has priority over clear.
         if (abort)            err_q <= 1'b1;
         else if (bus.err_clr) err_q <= 1'b0;
      end
   end

   assign bus.din_ready  = ready;
   assign bus.i          = i_q;
   assign bus.s          = s_q;
   assign bus.y_valid    = y_valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.err        = err_q;
   assign bus.cnt0       = cnt0_q;
   assign bus.cnt1       = cnt1_q;

endmodule : demux_frame_ctrl

// File: tb/tb_demux_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_demux_frame_ctrl
// Directed bench for demux_frame_ctrl with PLEN=4. Inputs change on the
// falling edge; outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demux_frame_ctrl;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   demux_frame_ctrl_if bus ();

   demux_frame_ctrl #(.PLEN(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one beat (or an idle cycle when v=0) across one rising edge.
   task automatic step(input logic v, input logic sf, input logic d);
      @(negedge clk);
      bus.din_valid = v;
      bus.sof       = sf;
      bus.din       = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int done_seen;

      rst_n         = 1'b0;
      bus.din       = 1'b0;
      bus.din_valid = 1'b0;
      bus.sof       = 1'b0;
      bus.err_clr   = 1'b0;
      #1;
      check("rst_ready", bus.din_ready, 1);
      check("rst_yv",    bus.y_valid, 0);
      check("rst_s",     bus.s, 0);
      check("rst_cnt0",  bus.cnt0, 0);
      check("rst_err",   bus.err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Contiguous frame to channel 1: header, payload 1,0,1,1.
      step(1, 1, 1);
      check("h1_s",   bus.s, 1);
      check("h1_yv",  bus.y_valid, 0);
      step(1, 0, 1);
      check("f1_b0",  {bus.y_valid, bus.i}, 2'b11);
      step(1, 0, 0);
      check("f1_b1",  {bus.y_valid, bus.i}, 2'b10);
      step(1, 0, 1);
      check("f1_b2",  {bus.y_valid, bus.i, bus.frame_done}, 3'b110);
      check("f1_cnt1_pre", bus.cnt1, 0);
      step(1, 0, 1);
      check("f1_b3",  {bus.y_valid, bus.i, bus.frame_done}, 3'b111);
      check("f1_cnt1", bus.cnt1, 1);
      check("f1_gap_ready", bus.din_ready, 0);
      step(0, 0, 0);
      check("f1_idle", {bus.din_ready, bus.y_valid, bus.frame_done}, 3'b100);

      // Frame to channel 0 with idle cycles between beats: payload 0,1,1,0.
      step(1, 1, 0);
      check("h0_s", bus.s, 0);
      step(1, 0, 0);
      check("f2_b0", {bus.y_valid, bus.i}, 2'b10);
      step(0, 0, 1);
      check("f2_gap0", {bus.y_valid, bus.i}, 2'b00);
      step(1, 0, 1);
      check("f2_b1", {bus.y_valid, bus.i}, 2'b11);
      step(0, 0, 0);
      check("f2_gap1", bus.y_valid, 0);
      step(1, 0, 1);
      check("f2_b2", {bus.y_valid, bus.i, bus.frame_done}, 3'b110);
      step(0, 0, 0);
      step(1, 0, 0);
      check("f2_b3", {bus.y_valid, bus.i, bus.frame_done}, 3'b101);
      check("f2_cnt0", bus.cnt0, 1);
      check("f2_cnt1", bus.cnt1, 1);
      step(0, 0, 0);
      check("f2_s_hold", bus.s, 0);

      // Abort: header 1, two payload beats, then a header to channel 0.
      step(1, 1, 1);
      step(1, 0, 1);
      step(1, 0, 0);
      step(1, 1, 0);
      check("ab_err",  bus.err, 1);
      check("ab_out",  {bus.y_valid, bus.frame_done}, 2'b00);
      check("ab_s",    bus.s, 0);
      check("ab_cnt1", bus.cnt1, 1);
      step(1, 0, 1);
      step(1, 0, 0);
      step(1, 0, 1);
      step(1, 0, 1);
      check("ab_done", bus.frame_done, 1);
      check("ab_cnt0", bus.cnt0, 2);
      check("ab_cnt1_hold", bus.cnt1, 1);
      step(0, 0, 0);
      bus.err_clr = 1'b1;
      step(0, 0, 0);
      bus.err_clr = 1'b0;
      check("clr_err", bus.err, 0);

      // Set wins over clear in the same cycle.
      step(1, 1, 1);
      bus.err_clr = 1'b1;
      step(1, 1, 1);
      bus.err_clr = 1'b0;
      check("set_wins", bus.err, 1);
      bus.err_clr = 1'b1;
      step(0, 0, 0);
      bus.err_clr = 1'b0;
      check("clr_err2", bus.err, 0);
      // Finish this frame to channel 1.
      repeat (4) step(1, 0, 0);
      check("f4_cnt1", bus.cnt1, 2);
      step(0, 0, 0);

      // Non-sof beats in IDLE are discarded.
      step(1, 0, 1);
      check("idle_b0", bus.y_valid, 0);
      step(1, 0, 1);
      step(1, 0, 1);
      check("idle_b2", {bus.y_valid, bus.frame_done}, 2'b00);
      check("idle_cnt", {bus.cnt0, bus.cnt1}, {8'd2, 8'd2});
      check("idle_s", bus.s, 1);
      step(1, 1, 0);
      check("idle_hdr", bus.s, 0);
      repeat (3) step(1, 0, 1);
      step(1, 0, 1);
      check("f5_done", {bus.frame_done, bus.din_ready}, 2'b10);
      check("f5_cnt0", bus.cnt0, 3);

      // A header offered during GAP is held off, then taken in IDLE.
      step(1, 1, 1);
      check("gap_hold_s", bus.s, 0);
      check("gap_ready", bus.din_ready, 1);
      step(1, 1, 1);
      check("gap_hdr_s", bus.s, 1);

      // Error, then asynchronous reset mid-frame.
      step(1, 0, 1);
      step(1, 1, 1);
      step(1, 0, 1);
      check("pre_rst", {bus.y_valid, bus.i, bus.err}, 3'b111);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_out", {bus.i, bus.s, bus.y_valid, bus.frame_done, bus.err}, 5'b00000);
      check("arst_ready", bus.din_ready, 1);
      check("arst_cnt", {bus.cnt0, bus.cnt1}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      // Rest of the interrupted frame is discarded.
      step(1, 0, 1);
      step(1, 0, 1);
      step(1, 0, 1);
      check("post_rst", {bus.y_valid, bus.frame_done, bus.cnt0, bus.cnt1}, 18'h0);

      // 256 frames to channel 0: counter wraps.
      done_seen = 0;
      for (int f = 0; f < 256; f++) begin
         step(1, 1, 0);
         for (int b = 0; b < 4; b++) begin
            step(1, 0, b[0]);
            if (bus.frame_done === 1'b1) done_seen++;
         end
         if (f == 254) check("wrap_255", bus.cnt0, 255);
         step(0, 0, 0);
      end
      check("wrap_done_cnt", done_seen, 256);
      check("wrap_cnt0", bus.cnt0, 0);
      check("wrap_cnt1", bus.cnt1, 0);
      check("wrap_err", bus.err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_demux_frame_ctrl
